// File: rtl/i2c_wr_master_if.sv
// Command/status and SCL signals between on-chip logic and the I2C write master.
interface i2c_wr_master_if;
  logic       start;
  logic [7:0] reg_addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       scl;

  modport master (
    input  start, reg_addr, wdata,
    output busy, done, ack_err, scl
  );

  modport slave (
    output start, reg_addr, wdata,
    input  busy, done, ack_err, scl
  );
endinterface

// File: rtl/i2c_wr_master.sv
// Single-byte I2C register write master: START, device ID, register address,
// data byte (each with an ACK slot), then STOP. A NACK aborts straight to STOP.
module i2c_wr_master #(
  parameter int unsigned CLK_DIV   = 5,
  parameter logic [7:0]  DEV_ID    = 8'hA0,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  i2c_wr_master_if.master bus,
  inout  wire             sda
);

  localparam int unsigned QW = $clog2(CLK_DIV);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ID,
    S_ID_ACK,
    S_REG,
    S_REG_ACK,
    S_DATA,
    S_DATA_ACK,
    S_STOP
  } state_t;

  state_t        r_state,    w_state_nxt;
  logic [QW-1:0] r_qcnt,     w_qcnt_nxt;
  logic [1:0]    r_quarter,  w_quarter_nxt;
  logic [2:0]    r_bit,      w_bit_nxt;
  logic [7:0]    r_reg_addr, w_reg_addr_nxt;
  logic [7:0]    r_wdata,    w_wdata_nxt;
  logic          r_busy,     w_busy_nxt;
  logic          r_done,     w_done_nxt;
  logic          r_ack_err,  w_ack_err_nxt;
  logic          r_scl,      w_scl_nxt;
  logic          r_sda_oe,   w_sda_oe_nxt;

  logic          w_qtick;
  logic          w_slot_end;
  logic          w_sda_in;
  logic          w_ack_slot;
  logic [7:0]    w_byte;
  logic [2:0]    w_bit_idx;
  logic          w_bit_val;
  logic          w_sda_lvl;

  assign w_qtick    = (r_qcnt == QW'(CLK_DIV - 1));
  assign w_slot_end = w_qtick && (r_quarter == 2'd3);
  assign w_sda_in   = sda;
  assign w_ack_slot = (r_state inside {S_ID_ACK, S_REG_ACK, S_DATA_ACK});

  // Next-state logic: command accept, quarter/bit timing, ACK sampling, slot sequencing.
  always_comb begin
    w_state_nxt    = r_state;
    w_qcnt_nxt     = r_qcnt;
    w_quarter_nxt  = r_quarter;
    w_bit_nxt      = r_bit;
    w_reg_addr_nxt = r_reg_addr;
    w_wdata_nxt    = r_wdata;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_ack_err_nxt  = r_ack_err;

    if (r_state == S_IDLE) begin
      w_qcnt_nxt    = '0;
      w_quarter_nxt = '0;
      w_bit_nxt     = '0;
      if (bus.start) begin
        w_state_nxt    = S_START;
        w_reg_addr_nxt = bus.reg_addr;
        w_wdata_nxt    = bus.wdata;
        w_busy_nxt     = 1'b1;
        w_ack_err_nxt  = 1'b0;
      end
    end else begin
      if (w_qtick) begin
        w_qcnt_nxt    = '0;
        w_quarter_nxt = r_quarter + 2'd1;
      end else begin
        w_qcnt_nxt = r_qcnt + QW'(1);
      end

      // ACK is sampled on the last clk of q2, while SCL is high.
      if (w_ack_slot && w_qtick && (r_quarter == 2'd2) && w_sda_in) begin
        w_ack_err_nxt = 1'b1;
      end

      if (w_slot_end) begin
        case (r_state)
          S_START: begin
            w_state_nxt = S_ID;
            w_bit_nxt   = '0;
          end
          S_ID: begin
            w_bit_nxt = r_bit + 3'd1;
            if (r_bit == 3'd7) w_state_nxt = S_ID_ACK;
          end
          S_REG: begin
            w_bit_nxt = r_bit + 3'd1;
            if (r_bit == 3'd7) w_state_nxt = S_REG_ACK;
          end
          S_DATA: begin
            w_bit_nxt = r_bit + 3'd1;
            if (r_bit == 3'd7) w_state_nxt = S_DATA_ACK;
          end
          // ack_err is cleared on accept, so here it reflects only this transaction.
          S_ID_ACK:   w_state_nxt = r_ack_err ? S_STOP : S_REG;
          S_REG_ACK:  w_state_nxt = r_ack_err ? S_STOP : S_DATA;
          S_DATA_ACK: w_state_nxt = S_STOP;
          S_STOP: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end
          default: w_state_nxt = S_IDLE;
        endcase
      end
    end
  end

  // Bus level decode from the next state so SCL/SDA register on quarter boundaries.
  always_comb begin
    case (w_state_nxt)
      S_REG:   w_byte = w_reg_addr_nxt;
      S_DATA:  w_byte = w_wdata_nxt;
      default: w_byte = DEV_ID;
    endcase
    w_bit_idx = MSB_FIRST ? (3'd7 - w_bit_nxt) : w_bit_nxt;
    w_bit_val = w_byte[w_bit_idx];

    w_scl_nxt = 1'b1;
    w_sda_lvl = 1'b1;
    case (w_state_nxt)
      S_START: begin
        w_scl_nxt = (w_quarter_nxt != 2'd3);
        w_sda_lvl = (w_quarter_nxt < 2'd2);
      end
      S_ID, S_REG, S_DATA: begin
        w_scl_nxt = (w_quarter_nxt inside {2'd1, 2'd2});
        w_sda_lvl = w_bit_val;
      end
      S_ID_ACK, S_REG_ACK, S_DATA_ACK: begin
        w_scl_nxt = (w_quarter_nxt inside {2'd1, 2'd2});
        w_sda_lvl = 1'b1;
      end
      S_STOP: begin
        w_scl_nxt = (w_quarter_nxt != 2'd0);
        w_sda_lvl = (w_quarter_nxt >= 2'd2);
      end
      default: begin
        w_scl_nxt = 1'b1;
        w_sda_lvl = 1'b1;
      end
    endcase
    // Open drain: only a 0 is ever driven.
    w_sda_oe_nxt = ~w_sda_lvl;
  end

  // State and output registers; reset releases the bus immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_qcnt     <= '0;
      r_quarter  <= '0;
      r_bit      <= '0;
      r_reg_addr <= '0;
      r_wdata    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ack_err  <= 1'b0;
      r_scl      <= 1'b1;
      r_sda_oe   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_qcnt     <= w_qcnt_nxt;
      r_quarter  <= w_quarter_nxt;
      r_bit      <= w_bit_nxt;
      r_reg_addr <= w_reg_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_ack_err  <= w_ack_err_nxt;
      r_scl      <= w_scl_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.ack_err = r_ack_err;
  assign bus.scl     = r_scl;
  assign sda         = r_sda_oe ? 1'b0 : 1'bz;

endmodule
